// File: rtl/reduce_stream.sv
// Streaming OR/AND/XOR frame reducer with valid/ready on both sides.
// Optional per-frame popcount output enabled by REDUCE_STREAM_POPCNT_EN.
module reduce_stream #(
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 8,
  parameter int MODE_DEF = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
`ifdef REDUCE_STREAM_POPCNT_EN
 ,output logic [CNT_W+$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic [1:0]       mode_q, mode_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       xfer;
  logic [1:0] mode_in;
  logic [1:0] mode_use;
  logic       wres;

  function automatic logic word_red(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] d
  );
    case (m)
      2'd1:    return &d;
      2'd2:    return ^d;
      default: return |d;
    endcase
  endfunction

  function automatic logic acc_op(
    input logic [1:0] m,
    input logic       a,
    input logic       b
  );
    case (m)
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign xfer     = in_valid & in_ready;
  assign mode_in  = (in_mode == 2'd3) ? 2'(MODE_DEF) : in_mode;
  assign mode_use = (state_q == IDLE) ? mode_in : mode_q;
  assign wres     = word_red(mode_use, in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer) state_d = in_last ? DONE : ACC;
      ACC:  if (xfer && in_last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready stays low until the first edge after reset release
  always_comb begin
    in_ready   = live_q & (state_q != DONE);
    out_valid  = (state_q == DONE);
    out_result = out_valid & acc_q;
    out_count  = out_valid ? count_q : '0;
  end

  always_comb begin
    mode_d  = mode_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        mode_d  = mode_in;
        acc_d   = wres;
        count_d = CNT_W'(1);
      end else begin
        acc_d   = acc_op(mode_q, acc_q, wres);
        count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'd0;
      acc_q   <= 1'b0;
      count_q <= '0;
    end else begin
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

`ifdef REDUCE_STREAM_POPCNT_EN
  localparam int PW = CNT_W + $clog2(WIDTH + 1);

  logic [PW-1:0] pop_q, pop_d;
  logic [PW-1:0] wpop;

  always_comb begin
    wpop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wpop = wpop + PW'(in_data[i]);
    end
  end

  always_comb begin
    pop_d = pop_q;
    if (xfer) begin
      pop_d = (state_q == IDLE) ? wpop : pop_q + wpop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_q <= '0;
    else     pop_q <= pop_d;
  end

  assign out_popcnt = out_valid ? pop_q : '0;
`endif

endmodule

// File: tb/tb_reduce_stream.sv
// Scoreboard bench for reduce_stream (WIDTH=4, CNT_W=2, MODE_DEF=2).
module tb_reduce_stream;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int MD = 2;
  localparam int PW = CW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data;
  logic [1:0]    in_mode;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic          out_result;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;
`ifdef REDUCE_STREAM_POPCNT_EN
  logic [PW-1:0] out_popcnt;
`endif

  reduce_stream #(
    .WIDTH(W),
    .CNT_W(CW),
    .MODE_DEF(MD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_mode(in_mode),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_result(out_result),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef REDUCE_STREAM_POPCNT_EN
   ,.out_popcnt(out_popcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          res;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pop;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int vcyc     = 0;

  logic          last_res;
  logic [CW-1:0] last_cnt;
  logic [PW-1:0] last_pop;

  // reference frame state
  logic       m_first = 1'b1;
  logic [1:0] m_mode;
  logic       m_acc;
  int         m_cnt;
  int         m_pop;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) vcyc++;
      if (out_valid && out_ready) begin
        last_res = out_result;
        last_cnt = out_count;
`ifdef REDUCE_STREAM_POPCNT_EN
        last_pop = out_popcnt;
`else
        last_pop = '0;
`endif
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 32'(out_result), 32'(e.res));
          chk("count", 32'(out_count), 32'(e.cnt));
`ifdef REDUCE_STREAM_POPCNT_EN
          chk("popcnt", 32'(out_popcnt), 32'(e.pop));
`endif
        end
      end
    end
  end

  function automatic logic ref_red(input logic [1:0] m,
                                   input logic [W-1:0] d);
    if (m == 2'd1) return &d;
    if (m == 2'd2) return ^d;
    return |d;
  endfunction

  // called at posedge+1; returns at posedge+1 after the word transfers
  task automatic send(input logic [W-1:0] d,
                      input logic [1:0] m,
                      input logic l);
    int n;
    logic [1:0] me;
    logic r;
    exp_t e;
    n = 0;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
    me = m_first ? ((m == 2'd3) ? 2'(MD) : m) : m_mode;
    r  = ref_red(me, d);
    if (m_first) begin
      m_mode = me;
      m_acc  = r;
      m_cnt  = 1;
      m_pop  = $countones(d);
    end else begin
      if (me == 2'd1)      m_acc = m_acc & r;
      else if (me == 2'd2) m_acc = m_acc ^ r;
      else                 m_acc = m_acc | r;
      m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
      m_pop = m_pop + $countones(d);
    end
    m_first = l;
    if (l) begin
      e.res = m_acc;
      e.cnt = CW'(m_cnt);
      e.pop = PW'(m_pop);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
`ifdef REDUCE_STREAM_POPCNT_EN
    chk("rst_out_popcnt", 32'(out_popcnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rdy_post_edge", 32'(in_ready), 32'd1);

    v0 = vcyc;
    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 16; d++) begin
        send(W'(d), 2'(m), 1'b1);
      end
    end
    drain();
    chk("valid_cycles", 32'(vcyc - v0), 32'd64);

    send(4'h1, 2'd2, 1'b0);
    send(4'h3, 2'd2, 1'b0);
    send(4'h7, 2'd2, 1'b1);
    drain();
    chk("xor3_res", 32'(last_res), 32'd0);
    chk("xor3_cnt", 32'(last_cnt), 32'd3);

    send(4'hF, 2'd1, 1'b0);
    send(4'hF, 2'd0, 1'b1);
    drain();
    chk("and_sw_ff", 32'(last_res), 32'd1);
    send(4'hF, 2'd1, 1'b0);
    send(4'hE, 2'd0, 1'b1);
    drain();
    chk("and_sw_fe", 32'(last_res), 32'd0);

    send(4'h2, 2'd0, 1'b0);
    idle(3);
    chk("gap_ready", 32'(in_ready), 32'd1);
    chk("gap_valid", 32'(out_valid), 32'd0);
    send(4'h0, 2'd0, 1'b1);
    drain();
    chk("gap_res", 32'(last_res), 32'd1);
    chk("gap_cnt", 32'(last_cnt), 32'd2);

    out_ready = 1'b0;
    send(4'h9, 2'd0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_res", 32'(out_result), 32'd1);
      chk("bp_cnt", 32'(out_count), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    chk("bp_valid_after", 32'(out_valid), 32'd0);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    send(4'hF, 2'd0, 1'b0);
    send(4'hF, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    m_first = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(4'h0, 2'd0, 1'b1);
    drain();
    chk("rst_mid_res", 32'(last_res), 32'd0);
    chk("rst_mid_cnt", 32'(last_cnt), 32'd1);

    out_ready = 1'b0;
    send(4'h5, 2'd0, 1'b1);
    #1;
    chk("done_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_done_valid", 32'(out_valid), 32'd0);
    chk("rst_done_res", 32'(out_result), 32'd0);
    chk("rst_done_cnt", 32'(out_count), 32'd0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) send(4'hF, 2'd0, (i == 4));
    drain();
    chk("sat_cnt", 32'(last_cnt), 32'd3);
    chk("sat_res", 32'(last_res), 32'd1);
`ifdef REDUCE_STREAM_POPCNT_EN
    chk("sat_pop", 32'(last_pop), 32'd20);
`endif
    for (int i = 0; i < 5; i++) send(4'h1, 2'd2, (i == 4));
    drain();
    chk("satx_cnt", 32'(last_cnt), 32'd3);
    chk("satx_res", 32'(last_res), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reduce_stream.md
Name: reduce_stream

Overview:
Parametrised, sequential successor to the combinational 4-bit OR reduction. It reduces a stream of WIDTH-bit words into one result bit per frame, using OR, AND or XOR as selected. A frame is a run of words ending in in_last. The block sits between a word producer and a status consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 4, bits per input word (>=1)
CNT_W, 8, width of the frame word counter
MODE_DEF, 0, mode used when in_mode=3 (0=OR, 1=AND, 2=XOR)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  input word
in_mode  input  2  0=OR, 1=AND, 2=XOR, 3=MODE_DEF; sampled on the first word of a frame only
in_last  input  1  marks the final word of a frame
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
out_result  output  1  frame reduction result
out_count  output  CNT_W  number of words in the frame (saturating)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is high, 1 from the first clk edge after release; out_valid=0, out_result=0, out_count=0; accumulator and latched mode cleared.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Word reduction, combinational per word: OR=|in_data, AND=&in_data, XOR=^in_data.
- Frame accumulation applies the same operator across word results. The accumulator seeds with the first word's result; there is no identity-element preload.
- FSM IDLE:
  - in_ready=1.
  - On a transfer, latch the mode (in_mode, or MODE_DEF when in_mode=3), load acc=word result, count=1.
  - If in_last, go to DONE; else go to ACC.
- FSM ACC:
  - in_ready=1; the latched mode is used and in_mode is ignored.
  - On a transfer: acc = acc op word result; count = count+1, saturating at 2^CNT_W-1.
  - If in_last, go to DONE.
- FSM DONE:
  - in_ready=0; out_valid=1; out_result=acc; out_count=count.
  - Outputs hold stable until the output transfer, then the FSM goes to IDLE.
  - There is no same-cycle bypass back into IDLE, so there is one bubble per frame.
- Latency: out_valid rises on the clock edge that accepts the in_last word, so the result is visible in the following cycle.
- Throughput: one word per cycle inside a frame. Minimum frame period is 2 cycles when out_ready=1.
- Boundaries:
  - Single-word frame (first word has in_last=1): goes IDLE->DONE with count=1.
  - Counter saturation: count sticks at max and acc keeps accumulating.
  - in_valid=0 mid-frame: state and acc hold.
  - out_ready held low: DONE holds indefinitely and input stays blocked.
  - rst asserted mid-frame or in DONE: the partial frame is discarded and all outputs clear immediately.
  - in_data X while in_valid=0: ignored.

Optional Feature:
REDUCE_STREAM_POPCNT_EN
- Defined:
  - Adds output port out_popcnt (CNT_W+$clog2(WIDTH+1) bits), the total number of 1 bits across all words of the frame.
  - It is cleared on rst, loaded on the first word, summed thereafter and non-saturating.
  - It is valid and stable alongside out_valid.
- Undefined: the port, adder and register are absent and all other behaviour is identical.

Test Plan:
- Exhaustive single-word frames, WIDTH=4, in_data=0..15, in_last=1, each mode 0/1/2, out_ready=1.
  - Mode 0: out_result=|d. Mode 1: out_result=&d. Mode 2: out_result=^d.
  - Every frame: out_count=1; out_valid is high in exactly one cycle.
- Three-word XOR frame 4'h1, 4'h3, 4'h7 (last on 3rd): word results 1, 0, 1 -> out_result=0, out_count=3.
- Change in_mode mid-frame:
  - AND frame 4'hF, 4'hF with in_mode switched to 0 on word 2 -> out_result=1.
  - Same frame with word 2 = 4'hE -> out_result=0.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> in_ready=0 and out_result/out_count stable; release -> one transfer, then in_ready=1 next cycle.
- Assert rst mid-frame after 2 words -> out_valid=0 and in_ready=0 asynchronously; the next frame 4'h0 (OR, last) yields out_result=0, count=1.
- CNT_W=2, 5-word OR frame -> out_count=3 (saturated).
  - With REDUCE_STREAM_POPCNT_EN, words 4'hF x5 -> out_popcnt=20.
